// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared state encoding and sizing constants for the mux scan controller
package mux_scan_pkg;
  localparam int N_IN = 16;
  localparam int SEL_W = 4;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/mux_scan_dwell.sv
// mux_scan_dwell: counts DWELL cycles per select value and flags the last one
module mux_scan_dwell #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);
  logic [3:0] cnt_q, cnt_d;
  assign last_o = cnt_q == 4'(DWELL - 1);
  // next count: clear wins, otherwise wrap on the last dwell cycle
  always_comb cnt_d = clr_i ? 4'd0 : en_i ? (last_o ? 4'd0 : cnt_q + 4'd1) : cnt_q;
  // counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: walks an external 16:1 mux select, captures each bit and reassembles the word
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [N_IN-1:0]  word_in,
  output logic [N_IN-1:0]  mux_in,
  output logic [SEL_W-1:0] sel,
  input  logic             mux_out,
  output logic             busy,
  output logic [N_IN-1:0]  data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             mismatch
);
  if (DWELL < 1 || DWELL > 15) begin : g_bad_dwell
    $error("mux_scan_ctrl: DWELL must be within 1..15");
  end
  state_t           state_q;
  logic [SEL_W-1:0] sel_q;
  logic [N_IN-1:0]  mux_in_q, cap_q, cap_d, data_out_q;
  logic             data_valid_q, mismatch_q, last, accept;
  assign accept      = start_valid && state_q == IDLE;
  assign start_ready = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign mux_in      = mux_in_q;
  assign sel         = sel_q;
  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign mismatch    = mismatch_q;
  mux_scan_dwell #(.DWELL(DWELL)) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .en_i   (state_q == SCAN),
    .last_o (last)
  );
  // capture image including the bit sampled this cycle, so the final bit reaches data_out
  always_comb begin
    cap_d = cap_q;
    if (state_q == SCAN && last) cap_d[sel_q] = mux_out;
  end
  // scan FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      mux_in_q     <= '0;
      cap_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start_valid) begin
          mux_in_q <= word_in;
          sel_q    <= '0;
          state_q  <= SCAN;
        end
        SCAN: begin
          cap_q <= cap_d;
          if (last) begin
            if (sel_q == SEL_W'(N_IN - 1)) begin
              state_q      <= DONE;
              data_out_q   <= cap_d;
              mismatch_q   <= |(cap_d ^ mux_in_q);
              data_valid_q <= 1'b1;
            end else sel_q <= sel_q + 1'b1;
          end
        end
        DONE: if (data_ready) begin
          state_q      <= IDLE;
          data_valid_q <= 1'b0;
          sel_q        <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n.
REQ-002 Parameter DWELL, default 1, SHALL set the cycles each select value is held before sampling; legal range is 1..15.
REQ-003 Port clk, input, width 1: rising-edge clock for all state.
REQ-004 Port rst_n, input, width 1: asynchronous active-low reset.
REQ-005 Port start_valid, input, width 1: request to scan word_in.
REQ-006 Port start_ready, output, width 1: the block can accept a request.
REQ-007 Port word_in, input, width 16: word to present to the downstream 16:1 mux.
REQ-008 Port mux_in, output, width 16: registered copy of word_in, driven to the mux data input.
REQ-009 Port sel, output, width 4: mux select.
REQ-010 Port mux_out, input, width 1: mux result, sampled by this block.
REQ-011 Port busy, output, width 1: high in SCAN or DONE.
REQ-012 Port data_out, output, width 16: reassembled captured word.
REQ-013 Port data_valid, output, width 1: data_out and mismatch are valid.
REQ-014 Port data_ready, input, width 1: consumer accepts data_out.
REQ-015 Port mismatch, output, width 1: data_out differs from mux_in.

Function
REQ-016 The FSM SHALL have three states: IDLE, SCAN and DONE.
REQ-017 start_ready SHALL equal 1 only in IDLE.
REQ-018 A start is accepted on an edge where start_valid and start_ready are both 1.
- On accept: mux_in <= word_in, sel <= 0, dwell count <= 0, state <= SCAN.
REQ-019 In SCAN, each sel value SHALL be held for exactly DWELL cycles.
- mux_out SHALL be captured into capture bit [sel] on the last cycle of each dwell.
REQ-020 After the capture at sel=15, the FSM SHALL enter DONE.
- sel SHALL remain 15.
- Otherwise sel SHALL increment by 1 with no wrap inside SCAN.
REQ-021 In DONE, data_valid SHALL be 1 and data_out SHALL equal the capture register.
- mismatch SHALL equal the OR-reduction of (capture XOR mux_in).
REQ-022 Latency: with accept at edge T0, data_valid SHALL first be high in the cycle after edge T0+16*DWELL.
- Example: 17 cycles for DWELL=1.
REQ-023 data_out, data_valid and mismatch SHALL remain stable in DONE until data_ready=1.
- On that edge the FSM SHALL go to IDLE, data_valid <= 0 and sel <= 0.
- data_out SHALL hold its last value.
REQ-024 start_valid outside IDLE SHALL be ignored, with no reload of mux_in.
- If start_valid and data_ready are both high in DONE, only the data handshake occurs.
- The start is accepted no earlier than the next cycle.
REQ-025 mux_in SHALL NOT change during SCAN or DONE.
REQ-026 DWELL outside 1..15 SHALL cause an elaboration-time error.

Reset
REQ-027 While rst_n=0, the state SHALL be IDLE and all of the following SHALL be 0:
- sel, mux_in, data_out, data_valid, mismatch, busy
- the capture register and the dwell counter
REQ-028 Assertion of rst_n mid-SCAN or in DONE SHALL abort immediately, with no data_valid pulse after release.
REQ-029 start_ready SHALL be 1 from the first cycle after rst_n deasserts.

Structure
REQ-030 Shared package mux_scan_pkg SHALL hold:
- the state encoding (IDLE, SCAN, DONE)
- constants N_IN=16 and SEL_W=4
REQ-031 The dwell counter SHALL be one sub-module, mux_scan_dwell.
- It takes DWELL, clear and enable inputs and produces a last-cycle flag.
REQ-032 The 16:1 mux SHALL be instantiated outside this block, in the bench or the parent.

Verification
REQ-033 DWELL=1, word_in=16'hAAAA, ideal mux model:
- sel steps 0..15 one per cycle.
- data_valid is high 17 cycles after accept, with data_out=16'hAAAA and mismatch=0.
REQ-034 DWELL=3, word_in=16'h1234:
- each sel value is held 3 cycles.
- data_valid is high 49 cycles after accept, with data_out=16'h1234.
REQ-035 Mux model with bit 5 stuck-at-0, word_in=16'hFFFF -> data_out=16'hFFDF, mismatch=1.
REQ-036 data_ready held 0 for 10 cycles in DONE:
- data_out, data_valid and mismatch stay stable and start_ready stays 0.
- The data_ready pulse returns the FSM to IDLE on the next cycle.
REQ-037 start_valid pulsed with word_in=16'h0F0F during SCAN of 16'h5555 -> ignored, mux_in stays 16'h5555.
REQ-038 rst_n pulsed low at sel=7:
- all outputs go to 0 asynchronously.
- start_ready=1 after release, with no data_valid.
